// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_CPU     = 2'd0,
        ARB_BURST   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam logic [2:0] DMA_FUNCT3 = 3'b010;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating activity counters for the data-memory arbiter (DMEM_ARB_STATS_EN builds).
module dmem_arb_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        beat,
    output logic [15:0] stat_stall_cnt,
    output logic [15:0] stat_dma_beats
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_stall_cnt <= '0;
            stat_dma_beats <= '0;
        end else begin
            if (stall && (stat_stall_cnt != '1))
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            if (beat && (stat_dma_beats != '1))
                stat_dma_beats <= stat_dma_beats + 16'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage vs. DMA master, bounded DMA bursts.
// Optional statistics counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int BURST_MAX  = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_stall,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic                  dma_last,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_W-1:0]     dma_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_stall_cnt,
    output logic [15:0]           stat_dma_beats
`endif
);

    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_MAX - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    arb_state_e    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          cpu_pend, gnt_raw, gnt_cpu;

    assign cpu_pend  = cpu_rd | cpu_wr;
    // Gating with reset keeps the memory idle while reset is held.
    assign dma_gnt   = gnt_raw & reset;
    assign gnt_cpu   = cpu_pend & ~dma_gnt & reset;
    assign cpu_stall = cpu_pend & dma_gnt;
    assign cpu_rdata = mem_rdata;

    always_comb begin
        gnt_raw = 1'b0;
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ARB_CPU: begin
                gnt_raw = dma_req & (~cpu_pend | (starve_q == STARVE_MAX));
                if (gnt_raw && !dma_last) begin
                    if (BURST_MAX == 1) begin
                        state_d = ARB_RELEASE;
                    end else begin
                        state_d = ARB_BURST;
                        beat_d  = BW'(1);
                    end
                end
            end
            ARB_BURST: begin
                gnt_raw = dma_req;
                if (!dma_req || dma_last) begin
                    state_d = ARB_CPU;
                    beat_d  = '0;
                end else if (beat_q == BEAT_LAST) begin
                    state_d = ARB_RELEASE;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ARB_RELEASE: begin
                gnt_raw = dma_req & ~cpu_pend;
                state_d = ARB_CPU;
                beat_d  = '0;
            end
            default: begin
                state_d = ARB_CPU;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        starve_d = '0;
        if (dma_req && !dma_gnt)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_funct3 = cpu_funct3;
        if (dma_gnt) begin
            mem_rd     = ~dma_we;
            mem_wr     = dma_we;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            mem_funct3 = DMA_FUNCT3;
        end else if (gnt_cpu) begin
            mem_rd = cpu_rd;
            mem_wr = cpu_wr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_CPU;
            beat_q     <= '0;
            starve_q   <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            starve_q   <= starve_d;
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we)
                dma_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk            (clk),
        .reset          (reset),
        .stall          (cpu_stall),
        .beat           (dma_gnt),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_dma_beats (stat_dma_beats)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (stats checked when DMEM_ARB_STATS_EN).
module tb_dmem_arbiter;

    localparam int DATA_W     = 32;
    localparam int DM_ADDRESS = 9;
    localparam int BURST_MAX  = 8;
    localparam int STARVE_LIM = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [DM_ADDRESS-1:0] cpu_addr = '0;
    logic [DATA_W-1:0]     cpu_wdata = '0;
    logic [2:0]            cpu_funct3 = '0;
    logic                  cpu_stall;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
    logic [DM_ADDRESS-1:0] dma_addr = '0;
    logic [DATA_W-1:0]     dma_wdata = '0;
    logic                  dma_gnt, dma_rvalid;
    logic [DATA_W-1:0]     dma_rdata;
    logic                  mem_rd, mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]           stat_stall_cnt, stat_dma_beats;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W     (DATA_W),
        .DM_ADDRESS (DM_ADDRESS),
        .BURST_MAX  (BURST_MAX),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_funct3(cpu_funct3), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_stall_cnt(stat_stall_cnt), .stat_dma_beats(stat_dma_beats)
`endif
    );

    // Environment memory, driven only by the DUT's memory port.
    logic [DATA_W-1:0] ram     [0:(1<<DM_ADDRESS)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<DM_ADDRESS)-1];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_wr) ram[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats taken in the current burst, owed CPU slot, DMA wait count.
    int          m_beats, m_waits;
    bit          m_owe_cpu, last_gnt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    int          m_stat_stall, m_stat_beats;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_beats = 0; m_waits = 0; m_owe_cpu = 0; last_gnt = 0;
        exp_rvalid = 1'b0; exp_rdata = '0;
        m_stat_stall = 0; m_stat_beats = 0;
    endtask

    task automatic set_idle();
        cpu_rd = 0; cpu_wr = 0; dma_req = 0; dma_we = 0; dma_last = 0;
    endtask

    task automatic step(input logic crd, input logic cwr, input logic [8:0] caddr,
                        input logic [31:0] cwd, input logic [2:0] cf3,
                        input logic dreq, input logic dwe, input logic dlast,
                        input logic [8:0] daddr, input logic [31:0] dwd);
        bit pend, g, cg;
        @(negedge clk);
        cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd; cpu_funct3 = cf3;
        dma_req = dreq; dma_we = dwe; dma_last = dlast; dma_addr = daddr; dma_wdata = dwd;
        #1;
        check("dma_rvalid", dma_rvalid, exp_rvalid);
        check("dma_rdata", dma_rdata, exp_rdata);
`ifdef DMEM_ARB_STATS_EN
        check("stat_stall", stat_stall_cnt, m_stat_stall);
        check("stat_beats", stat_dma_beats, m_stat_beats);
`endif
        pend = crd | cwr;
        if (m_beats > 0)    g = dreq;
        else if (m_owe_cpu) g = dreq & !pend;
        else                g = dreq & (!pend || m_waits >= STARVE_LIM);
        cg = pend & !g;
        check("dma_gnt", dma_gnt, g);
        check("cpu_stall", cpu_stall, pend & g);
        check("mem_rd", mem_rd, g ? !dwe : (cg & crd));
        check("mem_wr", mem_wr, g ? dwe : (cg & cwr));
        if (g) begin
            check("mem_addr_dma", mem_addr, daddr);
            check("mem_funct3_dma", mem_funct3, 3'b010);
            if (dwe) check("mem_wdata_dma", mem_wdata, dwd);
        end else if (cg) begin
            check("mem_addr_cpu", mem_addr, caddr);
            check("mem_funct3_cpu", mem_funct3, cf3);
            if (cwr) check("mem_wdata_cpu", mem_wdata, cwd);
            if (crd) check("cpu_rdata", cpu_rdata, ref_mem[caddr]);
        end
        // Advance the model to the next cycle.
        exp_rvalid = g & !dwe;
        if (g && !dwe) exp_rdata = ref_mem[daddr];
        if (g && dwe) ref_mem[daddr] = dwd;
        else if (cg && cwr) ref_mem[caddr] = cwd;
        if (dreq && !g) m_waits = (m_waits < STARVE_LIM) ? m_waits + 1 : STARVE_LIM;
        else            m_waits = 0;
        if (m_beats > 0) begin
            if (!dreq || dlast) m_beats = 0;
            else if (m_beats + 1 >= BURST_MAX) begin m_beats = 0; m_owe_cpu = 1; end
            else m_beats++;
        end else if (m_owe_cpu) begin
            m_owe_cpu = 0;
        end else if (g && !dlast) begin
            if (BURST_MAX == 1) m_owe_cpu = 1;
            else                m_beats = 1;
        end
        if (pend && g && m_stat_stall < 16'hFFFF) m_stat_stall++;
        if (g && m_stat_beats < 16'hFFFF) m_stat_beats++;
        last_gnt = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        set_idle();
        #1;
        check("rst_rvalid", dma_rvalid, 1'b0);
        check("rst_rdata", dma_rdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        int k, run1, run0, phase;
        bit q[$];
        for (int i = 0; i < (1 << DM_ADDRESS); i++) begin
            ram[i] = 32'h1000 + i;
            ref_mem[i] = 32'h1000 + i;
        end
        model_reset();

        // Reset state with requests present: nothing reaches memory.
        cpu_rd = 1; dma_req = 1;
        #2;
        check("rst_gnt", dma_gnt, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_rvalid0", dma_rvalid, 1'b0);
        do_reset();

        // Scenario 1: plain CPU load.
        step(1, 0, 9'h010, 0, 3'b010, 0, 0, 0, 0, 0);
        check("t1_mem_rd", mem_rd, 1'b1);
        check("t1_mem_addr", mem_addr, 9'h010);
        check("t1_rdata", cpu_rdata, 32'h1010);

        // Scenario 3: DMA write then read back.
        step(0, 0, 0, 0, 0, 1, 1, 1, 9'h020, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 1, 0, 1, 9'h020, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_rvalid", dma_rvalid, 1'b1);
        check("t3_rdata", dma_rdata, 32'hDEADBEEF);

        // Scenario 2 (and stats): CPU saturating, single-beat DMA every STARVE_LIM+1 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 9'h010, 0, 3'b010, 1, 1, 1, 9'h030, 32'(i));
            check("t2_gnt", dma_gnt, (i % (STARVE_LIM + 1)) == STARVE_LIM);
        end
`ifdef DMEM_ARB_STATS_EN
        @(posedge clk); #1;
        check("t6_beats", stat_dma_beats, 16'd4);
        check("t6_stall", stat_stall_cnt, 16'd4);
`endif

        // Scenario 4: 12-beat read burst, CPU store pending from beat 2.
        do_reset();
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 12; cyc++) begin
            step(0, k >= 1, 9'h040, $urandom, 3'b010, 1, 0, k == 11, 9'(k), 0);
            q.push_back(dma_gnt);
            if (last_gnt) k++;
        end
        check("t4_done", k, 12);
        run1 = 0; run0 = 0; phase = 0;
        foreach (q[i]) begin
            if (phase == 0) begin
                if (q[i]) run1++; else begin phase = 1; run0 = 1; end
            end else if (phase == 1) begin
                if (!q[i]) run0++; else phase = 2;
            end
        end
        check("t4_burst_len", run1, BURST_MAX);
        check("t4_wait_len", run0, STARVE_LIM);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scenario 5: reset mid-burst with a read outstanding.
        step(0, 0, 0, 0, 0, 1, 0, 0, 9'h001, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 9'h002, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 9'h003, 0);
        @(negedge clk);
        reset = 0; cpu_rd = 1; dma_req = 1;
        #1;
        check("t5_rvalid", dma_rvalid, 1'b0);
        check("t5_gnt", dma_gnt, 1'b0);
        check("t5_mem_rd", mem_rd, 1'b0);
        @(posedge clk); #1;
        check("t5_rvalid2", dma_rvalid, 1'b0);
        model_reset();
        @(negedge clk);
        set_idle();
        reset = 1;
        step(1, 0, 9'h011, 0, 3'b010, 1, 0, 0, 9'h005, 0);
        check("t5_cpu_first", cpu_stall, 1'b0);
        check("t5_cpu_mem_rd", mem_rd, 1'b1);

        // Randomized mixed traffic.
        for (int i = 0; i < 500; i++) begin
            int op;
            op = $urandom_range(0, 2);
            step(op == 1, op == 2, 9'($urandom_range(0, 15)), $urandom, 3'($urandom),
                 $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 3) == 0,
                 9'($urandom_range(0, 15)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Single-port data-memory arbiter between the pipeline MEM stage (CPU port) and a secondary bus master (DMA port: loader or debug).
- Sits between the EX/MEM register outputs and datamemory.
- At most one access reaches memory per cycle.
- CPU has default priority. DMA gets bounded bursts and starvation protection.
- Asserts cpu_stall, which the hazard logic uses to freeze PC, IF/ID, ID/EX and EX/MEM.

Parameters:
DATA_W, 32, data width
DM_ADDRESS, 9, memory address width
BURST_MAX, 8, max consecutive DMA beats while the CPU waits (>=1)
STARVE_LIM, 4, cycles a pending DMA beat may be denied before a forced grant (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_rd  in  1  MEM-stage load
cpu_wr  in  1  MEM-stage store
cpu_addr  in  DM_ADDRESS  byte address
cpu_wdata  in  DATA_W  store data
cpu_funct3  in  3  access size/sign
cpu_stall  out  1  CPU access not granted this cycle
cpu_rdata  out  DATA_W  load data (mem_rdata passthrough)
dma_req  in  1  beat valid
dma_we  in  1  1=write, 0=read
dma_last  in  1  final beat of burst
dma_addr  in  DM_ADDRESS  byte address
dma_wdata  in  DATA_W  write data
dma_gnt  out  1  beat accepted this cycle
dma_rvalid  out  1  read data valid, registered
dma_rdata  out  DATA_W  read data, registered
mem_rd, mem_wr  out  1 each  to datamemory
mem_addr  out  DM_ADDRESS
mem_wdata  out  DATA_W
mem_funct3  out  3
mem_rdata  in  DATA_W  combinational read data, same cycle

Behaviour:
- cpu_pend = cpu_rd | cpu_wr.
- Grant is combinational from the registered state and counters. gnt_cpu = cpu_pend & !dma_gnt.
- Memory mux:
  - gnt_cpu: CPU signals drive memory.
  - dma_gnt: mem_rd=!dma_we, mem_wr=dma_we, mem_funct3=DMA_FUNCT3 (word).
  - Otherwise mem_rd=mem_wr=0.
- cpu_stall = cpu_pend & dma_gnt.
- FSM states:
  - ARB_CPU: dma_gnt = dma_req & (!cpu_pend | starve_cnt==STARVE_LIM). On dma_gnt & !dma_last: go to ARB_BURST with beat_cnt=1, or to ARB_RELEASE if BURST_MAX==1.
  - ARB_BURST: dma_gnt = dma_req.
    - dma_req low: go to ARB_CPU (burst broken); the CPU is served this cycle.
    - dma_gnt & dma_last: go to ARB_CPU.
    - dma_gnt & beat_cnt==BURST_MAX-1 & !dma_last: go to ARB_RELEASE.
    - Otherwise beat_cnt++.
  - ARB_RELEASE: dma_gnt = dma_req & !cpu_pend. Always go to ARB_CPU next cycle, so the CPU gets at least one slot after a full burst.
- starve_cnt:
  - Increments, saturating at STARVE_LIM, each cycle dma_req & !dma_gnt.
  - Clears on dma_gnt or when !dma_req.
- beat_cnt: width $clog2(BURST_MAX+1). Clears on entry to ARB_CPU.
- DMA read return: the cycle after a granted DMA read, dma_rvalid=1 and dma_rdata=registered mem_rdata. dma_rdata holds its value otherwise. DMA writes complete at grant.
- Simultaneous CPU and DMA request in ARB_CPU with starve_cnt<STARVE_LIM: CPU wins.
- Reset (reset=0): state ARB_CPU; starve_cnt, beat_cnt, dma_rvalid, dma_rdata are 0. The combinational outputs follow from this. Reset mid-burst aborts the burst and drops any pending rvalid. No memory access is issued while reset is asserted.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds outputs stat_stall_cnt[15:0] and stat_dma_beats[15:0].
  - stat_stall_cnt: saturating count of cpu_stall cycles.
  - stat_dma_beats: saturating count of dma_gnt cycles.
  - Both cleared by reset.
- Undefined: ports and counters are absent. Arbitration is identical.

Decomposition:
- Package dmem_arb_pkg holds: typedef enum logic[1:0] arb_state_e {ARB_CPU, ARB_BURST, ARB_RELEASE}; localparam DMA_FUNCT3=3'b010.
- One natural sub-module: dmem_arb_stats, the two saturating counters, instantiated only under DMEM_ARB_STATS_EN.
- FSM and mux stay in dmem_arbiter.

Test Plan:
1. Reset release, cpu_rd=1, cpu_addr=0x10, no DMA -> mem_rd=1, mem_addr=0x10, cpu_stall=0, dma_gnt=0; cpu_rdata tracks mem_rdata.
2. cpu_rd held continuously, dma_req single beats (dma_last=1) from cycle 0 -> DMA denied cycles 0-3, dma_gnt=1 and cpu_stall=1 only in cycle 4, then pattern repeats every 5 cycles.
3. DMA write 0xDEADBEEF @0x20, then DMA read @0x20 with no CPU traffic -> mem_funct3=3'b010 for both; dma_rvalid=1 one cycle after the read grant with dma_rdata=0xDEADBEEF.
4. 12-beat DMA burst, cpu_wr asserted from beat 2 -> DMA holds memory for 8 beats, RELEASE cycle grants CPU (cpu_stall=0); DMA is then re-granted after STARVE_LIM waits.
5. Reset asserted at burst beat 3 with a read outstanding -> dma_rvalid=0 next cycle, state ARB_CPU, a CPU request after release is granted immediately.
6. With DMEM_ARB_STATS_EN, run scenario 2 for 20 cycles -> stat_dma_beats=4, stat_stall_cnt=4.
